dense_par: RTL and testbench

//  Fully-connected layer, LANES output neurons computed in parallel, fully pipelined.

---
 rtl/dense_par.sv | 219 +++++++++++++++++++++
 tb/tb_dense_par.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dense_par.sv
// Fully-connected layer: LANES neurons per group share a streamed input vector,
// followed by rounding, saturation, optional ReLU and a running argmax.
module dense_par #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned FRAC_BITS  = 7,
  parameter int unsigned IN_DIM     = 1568,
  parameter int unsigned OUT_DIM    = 10,
  parameter int unsigned LANES      = 2,
  parameter int unsigned POST_SHIFT = 4,
  parameter int unsigned ROUND_EN   = 1,
  parameter int unsigned RELU_EN    = 0,
  parameter logic [OUT_DIM*IN_DIM*DATA_WIDTH-1:0] W_INIT = '0,
  parameter logic [OUT_DIM*DATA_WIDTH-1:0]        B_INIT = '0
) (
  input  logic                                                clk,
  input  logic                                                reset_n,
  input  logic                                                start,
  output logic                                                busy,
  output logic [$clog2(IN_DIM)-1:0]                           in_addr,
  output logic                                                in_en,
  input  logic [DATA_WIDTH-1:0]                               in_q,
  output logic signed [DATA_WIDTH-1:0]                        out_vec [0:OUT_DIM-1],
  output logic [((OUT_DIM > 1) ? $clog2(OUT_DIM) : 1)-1:0]    out_argmax,
  output logic                                                done
);

  localparam int unsigned DW   = DATA_WIDTH;
  localparam int unsigned PW   = 2 * DW;
  localparam int unsigned IAW  = $clog2(IN_DIM);
  localparam int unsigned NG   = (OUT_DIM + LANES - 1) / LANES;
  localparam int unsigned GW   = (NG > 1) ? $clog2(NG) : 1;
  localparam int unsigned AMW  = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;
  localparam int unsigned ACCW = 2 * DW + $clog2(IN_DIM) + 1;
  localparam int unsigned SH   = FRAC_BITS + POST_SHIFT;

  localparam logic signed [ACCW-1:0] RND_C =
    (ROUND_EN != 0 && SH > 0) ? (ACCW'(1) << ((SH > 0) ? SH - 1 : 0)) : '0;
  localparam logic signed [ACCW-1:0] SAT_HI = {{(ACCW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACCW-1:0] SAT_LO = {{(ACCW-DW+1){1'b1}}, {(DW-1){1'b0}}};
  localparam logic signed [DW-1:0]   DW_MAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic signed [DW-1:0]   DW_MIN = {1'b1, {(DW-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE, S_RUN, S_DRAIN1, S_DRAIN2, S_WRITE, S_FINISH
  } state_e;

  // Lane-banked weight ROM: lane l of group g holds row g*LANES+l, zero past OUT_DIM.
  function automatic logic signed [DW-1:0] w_rom(input int unsigned lane,
                                                 input int unsigned grp,
                                                 input int unsigned idx);
    int unsigned o;
    o = grp * LANES + lane;
    if (o < OUT_DIM) return W_INIT[(o*IN_DIM+idx)*DW +: DW];
    return '0;
  endfunction

  function automatic logic signed [ACCW-1:0] bias_acc(input int unsigned lane,
                                                      input int unsigned grp);
    int unsigned o;
    logic signed [DW-1:0] b;
    o = grp * LANES + lane;
    b = '0;
    if (o < OUT_DIM) b = B_INIT[o*DW +: DW];
    return ACCW'(b) <<< FRAC_BITS;
  endfunction

  function automatic logic signed [DW-1:0] post(input logic signed [ACCW-1:0] a);
    logic signed [ACCW-1:0] r;
    logic signed [DW-1:0]   v;
    r = (a + RND_C) >>> SH;
    if (r > SAT_HI)      v = DW_MAX;
    else if (r < SAT_LO) v = DW_MIN;
    else                 v = DW'(r);
    if (RELU_EN != 0 && v[DW-1]) v = '0;
    return v;
  endfunction

  state_e                 state_q, state_d;
  logic [GW-1:0]          group_q, group_d;
  logic [IAW-1:0]         in_addr_q, in_addr_d;
  logic                   in_en_q, in_en_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   rd_vld_q, rd_vld_d;
  logic                   prod_vld_q, prod_vld_d;
  logic signed [DW-1:0]   w_q    [LANES];
  logic signed [DW-1:0]   w_d    [LANES];
  logic signed [PW-1:0]   prod_q [LANES];
  logic signed [PW-1:0]   prod_d [LANES];
  logic signed [ACCW-1:0] acc_q  [LANES];
  logic signed [ACCW-1:0] acc_d  [LANES];
  logic signed [DW-1:0]   post_c [LANES];
  logic signed [DW-1:0]   out_vec_q [OUT_DIM];
  logic signed [DW-1:0]   out_vec_d [OUT_DIM];
  logic signed [DW-1:0]   max_q, max_d;
  logic [AMW-1:0]         argmax_q, argmax_d;

  always_comb begin
    state_d    = state_q;
    group_d    = group_q;
    in_addr_d  = in_addr_q;
    in_en_d    = 1'b0;
    busy_d     = busy_q;
    done_d     = 1'b0;
    rd_vld_d   = in_en_q;
    prod_vld_d = rd_vld_q;
    out_vec_d  = out_vec_q;
    max_d      = max_q;
    argmax_d   = argmax_q;

    // Weight read aligned with the BRAM read, product one stage later, then accumulate.
    for (int l = 0; l < LANES; l++) begin
      w_d[l]    = in_en_q ? w_rom(l, 32'(group_q), 32'(in_addr_q)) : w_q[l];
      prod_d[l] = rd_vld_q ? PW'($signed(in_q)) * PW'(w_q[l]) : '0;
      acc_d[l]  = prod_vld_q ? acc_q[l] + ACCW'(prod_q[l]) : acc_q[l];
      post_c[l] = post(acc_q[l]);
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_RUN;
          in_en_d   = 1'b1;
          in_addr_d = '0;
          group_d   = '0;
          busy_d    = 1'b1;
          max_d     = DW_MIN;
          argmax_d  = '0;
          for (int l = 0; l < LANES; l++) acc_d[l] = bias_acc(l, 0);
        end
      end
      S_RUN: begin
        if (in_addr_q == IAW'(IN_DIM - 1)) begin
          state_d   = S_DRAIN1;
          in_addr_d = '0;
        end else begin
          in_en_d   = 1'b1;
          in_addr_d = in_addr_q + IAW'(1);
        end
      end
      S_DRAIN1: state_d = S_DRAIN2;
      S_DRAIN2: state_d = S_WRITE;
      S_WRITE: begin
        // Ascending index order with strict compare keeps the lowest index on ties.
        for (int o = 0; o < OUT_DIM; o++) begin
          if (GW'(o / LANES) == group_q) begin
            out_vec_d[o] = post_c[o % LANES];
            if (post_c[o % LANES] > max_d) begin
              max_d    = post_c[o % LANES];
              argmax_d = AMW'(o);
            end
          end
        end
        if (group_q == GW'(NG - 1)) begin
          state_d = S_FINISH;
          done_d  = 1'b1;
        end else begin
          state_d   = S_RUN;
          group_d   = group_q + GW'(1);
          in_en_d   = 1'b1;
          in_addr_d = '0;
          for (int l = 0; l < LANES; l++) acc_d[l] = bias_acc(l, 32'(group_q) + 1);
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      group_q    <= '0;
      in_addr_q  <= '0;
      in_en_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_vld_q   <= 1'b0;
      prod_vld_q <= 1'b0;
      max_q      <= '0;
      argmax_q   <= '0;
      for (int l = 0; l < LANES; l++) begin
        w_q[l]    <= '0;
        prod_q[l] <= '0;
        acc_q[l]  <= '0;
      end
      for (int o = 0; o < OUT_DIM; o++) out_vec_q[o] <= '0;
    end else begin
      state_q    <= state_d;
      group_q    <= group_d;
      in_addr_q  <= in_addr_d;
      in_en_q    <= in_en_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rd_vld_q   <= rd_vld_d;
      prod_vld_q <= prod_vld_d;
      max_q      <= max_d;
      argmax_q   <= argmax_d;
      w_q        <= w_d;
      prod_q     <= prod_d;
      acc_q      <= acc_d;
      out_vec_q  <= out_vec_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign in_en      = in_en_q;
  assign in_addr    = in_addr_q;
  assign out_argmax = argmax_q;

  always_comb begin
    for (int o = 0; o < OUT_DIM; o++) out_vec[o] = out_vec_q[o];
  end

endmodule

// File: tb/tb_dense_par.sv
// Bench for dense_par: three instances (round, round+ReLU, truncate) on a
// 4-input / 5-output / 2-lane layer, hand vectors plus a reference model.
module tb_dense_par;

  localparam int unsigned DW = 16;
  localparam int unsigned ND = 4;
  localparam int unsigned NO = 5;

  localparam logic [NO*ND*DW-1:0] WA = {20{16'h0080}};
  localparam logic [NO*DW-1:0]    BA = '0;
  localparam logic [NO*ND*DW-1:0] WC = {{7{16'h0000}}, 16'h0040, {3{16'h0000}}, 16'h0040,
                                        {4{16'h8001}}, {4{16'h7FFF}}};
  localparam logic [NO*DW-1:0]    BC = {16'h0001, 16'h0009, 16'hFFFE, 16'h0009, 16'h0003};

  logic clk, reset_n, start;
  logic [1:0] addr_a, addr_b, addr_c;
  logic en_a, en_b, en_c, busy_a, busy_b, busy_c, done_a, done_b, done_c;
  logic [15:0] q_a, q_b, q_c;
  logic signed [15:0] ov_a [0:NO-1];
  logic signed [15:0] ov_b [0:NO-1];
  logic signed [15:0] ov_c [0:NO-1];
  logic [2:0] am_a, am_b, am_c;
  logic [15:0] in_mem [ND];

  int n_cmp, n_bad, lat, busy_cnt, done_cnt;
  logic signed [15:0] exp_v [NO];
  int exp_arg;

  typedef struct packed {
    logic [63:0] in_v;
    logic [79:0] exp_c;
    logic [2:0]  arg_c;
    logic [15:0] b1;
    logic [15:0] b3;
    logic [15:0] a0;
    logic [2:0]  arg_a;
  } vec_t;
  vec_t vecs [5];

  dense_par #(.DATA_WIDTH(16), .FRAC_BITS(7), .IN_DIM(4), .OUT_DIM(5), .LANES(2),
              .POST_SHIFT(0), .ROUND_EN(1), .RELU_EN(0), .W_INIT(WA), .B_INIT(BA)) dut_a (
    .clk(clk), .reset_n(reset_n), .start(start), .busy(busy_a), .in_addr(addr_a),
    .in_en(en_a), .in_q(q_a), .out_vec(ov_a), .out_argmax(am_a), .done(done_a));
  dense_par #(.DATA_WIDTH(16), .FRAC_BITS(7), .IN_DIM(4), .OUT_DIM(5), .LANES(2),
              .POST_SHIFT(0), .ROUND_EN(1), .RELU_EN(1), .W_INIT(WC), .B_INIT(BC)) dut_b (
    .clk(clk), .reset_n(reset_n), .start(start), .busy(busy_b), .in_addr(addr_b),
    .in_en(en_b), .in_q(q_b), .out_vec(ov_b), .out_argmax(am_b), .done(done_b));
  dense_par #(.DATA_WIDTH(16), .FRAC_BITS(7), .IN_DIM(4), .OUT_DIM(5), .LANES(2),
              .POST_SHIFT(0), .ROUND_EN(0), .RELU_EN(0), .W_INIT(WC), .B_INIT(BC)) dut_c (
    .clk(clk), .reset_n(reset_n), .start(start), .busy(busy_c), .in_addr(addr_c),
    .in_en(en_c), .in_q(q_c), .out_vec(ov_c), .out_argmax(am_c), .done(done_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One-cycle-latency input BRAMs
  always @(posedge clk) if (en_a) q_a <= in_mem[addr_a];
  always @(posedge clk) if (en_b) q_b <= in_mem[addr_b];
  always @(posedge clk) if (en_c) q_c <= in_mem[addr_c];

  task automatic chk(input string nm, input logic signed [63:0] act,
                     input logic signed [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endtask

  function automatic logic signed [15:0] get_out(input int sel, input int o);
    case (sel)
      0: return ov_a[o];
      1: return ov_b[o];
      default: return ov_c[o];
    endcase
  endfunction

  function automatic int get_arg(input int sel);
    case (sel)
      0: return int'(am_a);
      1: return int'(am_b);
      default: return int'(am_c);
    endcase
  endfunction

  // Reference: dot product + bias in plain integers, floor division, clamp, ReLU, first max.
  task automatic model(input int sel, input bit rnd, input bit relu);
    logic [NO*ND*DW-1:0] wall;
    logic [NO*DW-1:0] ball;
    longint acc, v;
    wall = (sel == 0) ? WA : WC;
    ball = (sel == 0) ? BA : BC;
    for (int o = 0; o < NO; o++) begin
      acc = longint'($signed(ball[o*16 +: 16])) * 128;
      for (int i = 0; i < ND; i++)
        acc += longint'($signed(in_mem[i])) * longint'($signed(wall[(o*ND+i)*16 +: 16]));
      if (rnd) acc += 64;
      v = (acc >= 0) ? acc / 128 : -((-acc + 127) / 128);
      if (v > 32767) v = 32767;
      if (v < -32768) v = -32768;
      if (relu && v < 0) v = 0;
      exp_v[o] = 16'(v);
    end
    exp_arg = 0;
    for (int o = 1; o < NO; o++) if (exp_v[o] > exp_v[exp_arg]) exp_arg = o;
  endtask

  task automatic model_check(input string tag);
    for (int s = 0; s < 3; s++) begin
      model(s, s != 2, s == 1);
      for (int o = 0; o < NO; o++)
        chk($sformatf("%s_d%0d_out%0d", tag, s, o), get_out(s, o), exp_v[o]);
      chk($sformatf("%s_d%0d_argmax", tag, s), get_arg(s), exp_arg);
    end
  endtask

  // Starts one inference, then watches a bounded 50-cycle window (cycle k = k edges after start).
  task automatic run(input bit do_trace, input int pulse_at);
    bit exp_en;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1; busy_cnt = 0; done_cnt = 0;
    for (int k = 1; k <= 50; k++) begin
      if (busy_a) busy_cnt++;
      if (done_a) begin
        done_cnt++;
        if (lat < 0) lat = k;
      end
      if (do_trace) begin
        exp_en = (k <= 21) && (((k - 1) % 7) < 4);
        chk($sformatf("trace_en_c%0d", k), en_a, exp_en);
        if (exp_en) chk($sformatf("trace_addr_c%0d", k), addr_a, (k - 1) % 7);
      end
      start = (k == pulse_at);
      @(posedge clk); #1;
    end
    start = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    for (int s = 0; s < 3; s++) begin
      for (int o = 0; o < NO; o++) chk($sformatf("%s_d%0d_out%0d", tag, s, o), get_out(s, o), 0);
      chk($sformatf("%s_d%0d_argmax", tag, s), get_arg(s), 0);
    end
    chk({tag, "_busy"}, {busy_a, busy_b, busy_c}, 0);
    chk({tag, "_done"}, {done_a, done_b, done_c}, 0);
    chk({tag, "_en"}, {en_a, en_b, en_c}, 0);
    chk({tag, "_addr"}, {addr_a, addr_b, addr_c}, 0);
  endtask

  initial begin
    int cnt;
    n_cmp = 0; n_bad = 0;
    vecs[0] = '{in_v: {4{16'h0080}},
                exp_c: {16'd1, 16'd73, 16'd62, 16'h8000, 16'h7FFF}, arg_c: 3'd0,
                b1: 16'd0, b3: 16'd73, a0: 16'd512, arg_a: 3'd0};
    vecs[1] = '{in_v: {4{16'h7FFF}},
                exp_c: {16'd1, 16'd16392, 16'd16381, 16'h8000, 16'h7FFF}, arg_c: 3'd0,
                b1: 16'd0, b3: 16'd16393, a0: 16'd32767, arg_a: 3'd0};
    vecs[2] = '{in_v: {16'h0000, 16'h0000, 16'h0000, 16'h0001},
                exp_c: {16'd1, 16'd9, 16'hFFFE, 16'hFF09, 16'd258}, arg_c: 3'd0,
                b1: 16'd0, b3: 16'd10, a0: 16'd1, arg_a: 3'd0};
    vecs[3] = '{in_v: 64'h0,
                exp_c: {16'd1, 16'd9, 16'hFFFE, 16'd9, 16'd3}, arg_c: 3'd1,
                b1: 16'd9, b3: 16'd9, a0: 16'd0, arg_a: 3'd0};
    vecs[4] = '{in_v: {4{16'hFF80}},
                exp_c: {16'd1, 16'hFFC9, 16'hFFBE, 16'h7FFF, 16'h8000}, arg_c: 3'd1,
                b1: 16'd32767, b3: 16'd0, a0: 16'hFE00, arg_a: 3'd0};

    reset_n = 1'b0; start = 1'b0;
    for (int i = 0; i < ND; i++) in_mem[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    reset_n = 1'b1;
    @(posedge clk); #1;

    for (int v = 0; v < 5; v++) begin
      for (int i = 0; i < ND; i++) in_mem[i] = vecs[v].in_v[i*16 +: 16];
      run(v == 0, 0);
      chk($sformatf("vec%0d_latency", v), lat, 22);
      chk($sformatf("vec%0d_busy_cycles", v), busy_cnt, 22);
      chk($sformatf("vec%0d_done_pulses", v), done_cnt, 1);
      for (int o = 0; o < NO; o++)
        chk($sformatf("vec%0d_c_out%0d", v, o), ov_c[o], $signed(vecs[v].exp_c[o*16 +: 16]));
      chk($sformatf("vec%0d_c_argmax", v), am_c, vecs[v].arg_c);
      chk($sformatf("vec%0d_b_out1", v), ov_b[1], $signed(vecs[v].b1));
      chk($sformatf("vec%0d_b_out3", v), ov_b[3], $signed(vecs[v].b3));
      chk($sformatf("vec%0d_a_out0", v), ov_a[0], $signed(vecs[v].a0));
      chk($sformatf("vec%0d_a_out4", v), ov_a[4], $signed(vecs[v].a0));
      chk($sformatf("vec%0d_a_argmax", v), am_a, vecs[v].arg_a);
    end

    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < ND; i++)
        in_mem[i] = (r % 2 == 1) ? 16'($urandom) : 16'($urandom_range(0, 511)) - 16'd256;
      run(0, 0);
      chk($sformatf("rand%0d_latency", r), lat, 22);
      model_check($sformatf("rand%0d", r));
    end

    run(0, 10);
    chk("busy_start_latency", lat, 22);
    chk("busy_start_done_pulses", done_cnt, 1);
    chk("busy_start_busy_cycles", busy_cnt, 22);
    model_check("busy_start");

    run(0, 22);
    chk("finish_start_done_pulses", done_cnt, 1);
    chk("finish_start_busy_cycles", busy_cnt, 22);

    for (int i = 0; i < ND; i++) in_mem[i] = 16'($urandom);
    run(0, 23);
    chk("idle_restart_done_pulses", done_cnt, 2);
    chk("idle_restart_busy_cycles", busy_cnt, 44);
    model_check("idle_restart");

    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check_zero("abort");
    @(posedge clk); #1;
    reset_n = 1'b1;
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      if (done_a || done_b || done_c) cnt++;
      @(posedge clk); #1;
    end
    chk("abort_no_done", cnt, 0);
    chk("abort_idle_busy", busy_a, 0);

    for (int i = 0; i < ND; i++) in_mem[i] = 16'($urandom_range(0, 1023)) - 16'd512;
    run(0, 0);
    chk("after_abort_latency", lat, 22);
    model_check("after_abort");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
